// File: rtl/imm_extender_if.sv
// Bundle between the control/decode stage and the immediate generator:
// instruction bits [31:7] and format code in, registered immediate out.
interface imm_extender_if;
    logic        in_valid;
    logic [24:0] Inst;
    logic [1:0]  ImmExt;
    logic        out_valid;
    logic [31:0] Imm;

    modport master (
        output in_valid,
        output Inst,
        output ImmExt,
        input  out_valid,
        input  Imm
    );

    modport slave (
        input  in_valid,
        input  Inst,
        input  ImmExt,
        output out_valid,
        output Imm
    );
endinterface

// File: rtl/imm_extender.sv
// RV32 immediate generator: decodes I/B/S/J immediates from instr[31:7]
// and presents the sign-extended value one clock after the input is accepted.
module imm_extender (
    input  logic         clk,
    input  logic         rst_n,
    imm_extender_if.slave bus
);
    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_B = 2'b01;
    localparam logic [1:0] FMT_S = 2'b10;
    localparam logic [1:0] FMT_J = 2'b11;

    logic        sign_bit;
    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_s;
    logic [31:0] imm_j;
    logic [31:0] imm_next;
    logic [31:0] imm_reg;
    logic        valid_reg;

    // Inst[k] holds instr[k+7]; instr[31] (Inst[24]) is the sign for every format.
    assign sign_bit = bus.Inst[24];

    assign imm_i = {{20{sign_bit}}, bus.Inst[24:13]};

    assign imm_b = {{19{sign_bit}}, bus.Inst[24], bus.Inst[0],
                    bus.Inst[23:18], bus.Inst[4:1], 1'b0};

    assign imm_s = {{20{sign_bit}}, bus.Inst[24:18], bus.Inst[4:0]};

    assign imm_j = {{11{sign_bit}}, bus.Inst[24], bus.Inst[12:5],
                    bus.Inst[13], bus.Inst[23:14], 1'b0};

    always_comb begin
        imm_next = imm_i;
        case (bus.ImmExt)
            FMT_I:   imm_next = imm_i;
            FMT_B:   imm_next = imm_b;
            FMT_S:   imm_next = imm_s;
            FMT_J:   imm_next = imm_j;
            default: imm_next = imm_i;
        endcase
    end

    // Imm keeps its last value when idle; out_valid only marks fresh results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_reg   <= 32'h0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                imm_reg <= imm_next;
            end
        end
    end

    assign bus.Imm       = imm_reg;
    assign bus.out_valid = valid_reg;
endmodule

// File: tb/tb_imm_extender.sv
// Directed-vector bench for imm_extender: hand-computed immediates for each
// format, hold behaviour, asynchronous reset and back-to-back throughput.
module tb_imm_extender;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    imm_extender_if ibus ();

    imm_extender dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ibus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one input for exactly one edge and check the result 1 ns after it.
    task automatic apply(input string tag, input logic [24:0] inst, input logic [1:0] fmt,
                         input logic [31:0] exp_imm);
        @(negedge clk);
        ibus.in_valid = 1'b1;
        ibus.Inst     = inst;
        ibus.ImmExt   = fmt;
        @(posedge clk);
        #1;
        $display("txn %-10s Inst=%07h ImmExt=%0d -> Imm=%08h out_valid=%0b (exp %08h)",
                 tag, inst, fmt, ibus.Imm, ibus.out_valid, exp_imm);
        check_val({tag, "_imm"}, ibus.Imm, exp_imm);
        check_val({tag, "_vld"}, {31'd0, ibus.out_valid}, 32'd1);
    endtask

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        rst_n         = 1'b0;
        ibus.in_valid = 1'b0;
        ibus.Inst     = 25'h0;
        ibus.ImmExt   = 2'b00;

        repeat (2) @(posedge clk);
        #1;
        $display("txn reset      Imm=%08h out_valid=%0b", ibus.Imm, ibus.out_valid);
        check_val("rst_imm", ibus.Imm, 32'h0);
        check_val("rst_vld", {31'd0, ibus.out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("I",  25'b0000000001101110000100000, 2'b00, 32'h0000_0006);
        apply("B",  25'b0000000001101110000100110, 2'b01, 32'h0000_0006);
        apply("S",  25'b1000000001101110000100000, 2'b10, 32'hFFFF_F800);
        apply("J",  25'b0100010001101110000100100, 2'b11, 32'h000E_1446);

        // Idle cycle with changed Inst: value must hold, valid must drop.
        @(negedge clk);
        ibus.in_valid = 1'b0;
        ibus.Inst     = 25'h1FF_FFFF;
        ibus.ImmExt   = 2'b00;
        @(posedge clk);
        #1;
        $display("txn hold       Imm=%08h out_valid=%0b", ibus.Imm, ibus.out_valid);
        check_val("hold_imm", ibus.Imm, 32'h000E_1446);
        check_val("hold_vld", {31'd0, ibus.out_valid}, 32'd0);

        // Boundary patterns, issued back to back with in_valid held high.
        apply("I_ones", 25'h1FF_FFFF, 2'b00, 32'hFFFF_FFFF);
        apply("B_ones", 25'h1FF_FFFF, 2'b01, 32'hFFFF_FFFE);
        apply("J_ones", 25'h1FF_FFFF, 2'b11, 32'hFFFF_FFFE);
        apply("S_pos",  25'h0FF_FFFF, 2'b10, 32'h0000_07FF);
        apply("J_pos",  25'h0FF_FFFF, 2'b11, 32'h000F_FFFE);
        apply("B_pos",  25'h0FF_FFFF, 2'b01, 32'h0000_0FFE);

        // Asynchronous reset asserted between edges clears outputs at once.
        @(negedge clk);
        ibus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        $display("txn async_rst  Imm=%08h out_valid=%0b", ibus.Imm, ibus.out_valid);
        check_val("arst_imm", ibus.Imm, 32'h0);
        check_val("arst_vld", {31'd0, ibus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check_val("arst_hold_imm", ibus.Imm, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("post_rst", 25'b1000000001101110000100000, 2'b00, 32'hFFFF_F806);

        @(negedge clk);
        ibus.in_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
